// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a synchronous-read data memory.
// Builds byte-lane write masks, extracts and extends load data, and flags bad requests.
module dmem_access_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [5:0]        alucode,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       load_data,
    output logic              access_err,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_we,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata
);

    // Memory-access operation codes shared with the decoder.
    localparam logic [5:0] ALU_LB  = 6'd9;
    localparam logic [5:0] ALU_LH  = 6'd10;
    localparam logic [5:0] ALU_LW  = 6'd11;
    localparam logic [5:0] ALU_LBU = 6'd12;
    localparam logic [5:0] ALU_LHU = 6'd13;
    localparam logic [5:0] ALU_SB  = 6'd14;
    localparam logic [5:0] ALU_SH  = 6'd15;
    localparam logic [5:0] ALU_SW  = 6'd16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              is_load_q, is_store_q, err_q;
    logic [5:0]        alucode_q;
    logic [1:0]        off_q;
    logic [31:0]       sdata_q;
    logic [31:0]       load_data_q;
    logic [ADDR_W-1:0] dmem_addr_q;

    logic        op_store, op_load, misaligned, store_ok, load_ok, accept;
    logic [3:0]  we_mask;
    logic [31:0] wdata_lane, rd_shift, load_ext;

    // Address bits above the memory's word range wrap and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    always_comb begin
        op_store   = (alucode == ALU_SB) || (alucode == ALU_SH) || (alucode == ALU_SW);
        op_load    = (alucode == ALU_LB) || (alucode == ALU_LH) || (alucode == ALU_LW) ||
                     (alucode == ALU_LBU) || (alucode == ALU_LHU);
        misaligned = 1'b0;
        case (alucode)
            ALU_SH, ALU_LH, ALU_LHU: misaligned = addr[0];
            ALU_SW, ALU_LW:          misaligned = |addr[1:0];
            default:                 misaligned = 1'b0;
        endcase
        store_ok = is_store && !is_load && op_store && !misaligned;
        load_ok  = is_load && !is_store && op_load && !misaligned;
        accept   = (state_q == S_IDLE) && req_valid;
    end

    // NOTE: every combinational output gets a default before the case, so no latch is inferred.
    always_comb begin
        we_mask    = 4'b0000;
        wdata_lane = 32'h0;
        if (is_store_q) begin
            case (alucode_q)
                ALU_SB: begin
                    we_mask    = 4'b0001 << off_q;
                    wdata_lane = {24'h0, sdata_q[7:0]} << {off_q, 3'b000};
                end
                ALU_SH: begin
                    we_mask    = 4'b0011 << off_q;
                    wdata_lane = {16'h0, sdata_q[15:0]} << {off_q, 3'b000};
                end
                ALU_SW: begin
                    we_mask    = 4'b1111;
                    wdata_lane = sdata_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_shift = dmem_rdata >> {off_q, 3'b000};
        load_ext = 32'h0;
        case (alucode_q)
            ALU_LB:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            ALU_LBU: load_ext = {24'h0, rd_shift[7:0]};
            ALU_LH:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            ALU_LHU: load_ext = {16'h0, rd_shift[15:0]};
            ALU_LW:  load_ext = dmem_rdata;
            default: load_ext = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (store_ok)     state_d = S_WRITE;
                    else if (load_ok) state_d = S_READ;
                    else              state_d = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            err_q       <= 1'b0;
            alucode_q   <= 6'h0;
            off_q       <= 2'b00;
            sdata_q     <= 32'h0;
            load_data_q <= 32'h0;
            dmem_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_load_q   <= is_load;
                is_store_q  <= is_store;
                alucode_q   <= alucode;
                off_q       <= addr[1:0];
                sdata_q     <= store_data;
                err_q       <= !(store_ok || load_ok);
                load_data_q <= 32'h0;
                // Errors never touch memory, so the address bus keeps its previous value.
                if (store_ok || load_ok) dmem_addr_q <= addr[ADDR_W+1:2];
            end
            if (state_q == S_WAIT && is_load_q) load_data_q <= load_ext;
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign stall      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_WAIT) ||
                        ((state_q == S_IDLE) && req_valid);
    assign resp_valid = (state_q == S_RESP);
    assign access_err = (state_q == S_RESP) && err_q;
    assign load_data  = load_data_q;
    assign dmem_addr  = dmem_addr_q;
    // Reset gates the write strobe immediately so a write in flight is suppressed.
    assign dmem_we    = (state_q == S_WRITE && !rst) ? we_mask : 4'b0000;
    assign dmem_wdata = (state_q == S_WRITE) ? wdata_lane : 32'h0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized requests
// checked against a byte-addressed reference memory and per-request expectations.
module tb_dmem_access_ctrl;

    localparam int ADDR_W = 14;
    localparam int NWORDS = 1 << ADDR_W;

    localparam logic [5:0] LB  = 6'd9;
    localparam logic [5:0] LH  = 6'd10;
    localparam logic [5:0] LW  = 6'd11;
    localparam logic [5:0] LBU = 6'd12;
    localparam logic [5:0] LHU = 6'd13;
    localparam logic [5:0] SB  = 6'd14;
    localparam logic [5:0] SH  = 6'd15;
    localparam logic [5:0] SW  = 6'd16;
    localparam logic [5:0] ADD = 6'd17;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, is_load, is_store;
    logic [5:0]        alucode;
    logic [31:0]       addr, store_data;
    logic              stall, resp_valid, access_err;
    logic [31:0]       load_data;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_we;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0]       mem [0:NWORDS-1];
    bit                mem_loaded = 1'b0;
    logic [7:0]        ref_bytes [0:4*NWORDS-1];
    logic [ADDR_W-1:0] exp_daddr;

    dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_load(is_load), .is_store(is_store), .alucode(alucode), .addr(addr),
        .store_data(store_data), .stall(stall), .resp_valid(resp_valid),
        .load_data(load_data), .access_err(access_err), .dmem_addr(dmem_addr),
        .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // Synchronous-read data memory with byte enables.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int w = 0; w < NWORDS; w++) mem[w] <= init_word(w);
            mem_loaded <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (dmem_we[b]) mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
        dmem_rdata <= mem[dmem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        logic [31:0] v;
        for (int b = 0; b < 4; b++) v[8*b +: 8] = ref_bytes[4*w + b];
        return v;
    endfunction

    // One request, idle inputs afterwards; checks every cycle up to and including RESP.
    task automatic run_req(input logic ld, input logic st, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] sd);
        int          sz, exp_lat, lat, lane;
        bit          err, seen;
        logic [3:0]  ewe;
        logic [31:0] ewd, eld, raw;
        logic [15:0] ba;

        sz = size_of(op);
        ba = a[15:0];
        err = !((st && !ld && (op == SB || op == SH || op == SW)) ||
                (ld && !st && (op == LB || op == LH || op == LW || op == LBU || op == LHU))) ||
              (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
        exp_lat = err ? 1 : (st ? 2 : 3);
        ewe = 4'b0; ewd = 32'h0; eld = 32'h0; raw = 32'h0;
        if (!err && st)
            for (int k = 0; k < sz; k++) begin
                lane = int'(ba[1:0]) + k;
                ewe[lane] = 1'b1;
                ewd[8*lane +: 8] = sd[8*k +: 8];
            end
        if (!err && ld) begin
            for (int k = 0; k < sz; k++) raw[8*k +: 8] = ref_bytes[16'(ba + 16'(k))];
            eld = raw;
            if (op == LB && raw[7])  eld = eld | 32'hFFFFFF00;
            if (op == LH && raw[15]) eld = eld | 32'hFFFF0000;
        end
        if (!err) exp_daddr = a[ADDR_W+1:2];

        @(negedge clk);
        check("idle_resp", resp_valid, 0);
        req_valid = 1'b1; is_load = ld; is_store = st; alucode = op; addr = a; store_data = sd;
        #1;
        check("req_ready", req_ready, 1);
        check("stall_req", stall, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        is_load = 1'($urandom); is_store = 1'($urandom); alucode = 6'($urandom);
        addr = $urandom; store_data = $urandom;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            lat++;
            if (resp_valid) seen = 1'b1;
            else begin
                check("stall_busy", stall, 1);
                check("ready_busy", req_ready, 0);
                if (st && !err && lat == 1) begin
                    check("wr_we", dmem_we, ewe);
                    check("wr_wdata", dmem_wdata, ewd);
                    check("wr_addr", dmem_addr, exp_daddr);
                end else begin
                    check("no_we", dmem_we, 0);
                    if (!err) check("rd_addr", dmem_addr, exp_daddr);
                end
            end
        end
        check("resp_lat", lat, exp_lat);
        check("access_err", access_err, err);
        check("load_data", load_data, eld);
        check("stall_resp", stall, 0);
        check("we_resp", dmem_we, 0);
        check("addr_resp", dmem_addr, exp_daddr);
        if (!err && st)
            for (int k = 0; k < sz; k++) ref_bytes[16'(ba + 16'(k))] = sd[8*k +: 8];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w, a, eld;
        logic [5:0]  ops [9];
        logic [5:0]  op;
        logic        ld, st;
        int          kind;

        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADD};
        for (int i = 0; i < NWORDS; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = w[8*b +: 8];
        end
        exp_daddr = '0;
        rst = 1'b1; req_valid = 1'b1; is_load = 1'b0; is_store = 1'b1;
        alucode = SW; addr = 32'h0; store_data = 32'h0;

        // Reset: strobes gated while rst is high, outputs cleared afterwards.
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_we", dmem_we, 0);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_resp", resp_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_err", access_err, 0);
        check("rst_ldata", load_data, 0);
        check("rst_daddr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_ready_rel", req_ready, 1);

        // Directed scenarios.
        run_req(1'b0, 1'b1, SB, 32'h00000006, 32'h123456AB);
        run_req(1'b0, 1'b1, SW, 32'h00000010, 32'hDEADBEEF);
        run_req(1'b1, 1'b0, LB, 32'h00000013, 32'h0);
        run_req(1'b1, 1'b0, LBU, 32'h00000013, 32'h0);
        run_req(1'b1, 1'b0, LHU, 32'h00000012, 32'h0);
        run_req(1'b1, 1'b0, LH, 32'h00000012, 32'h0);
        run_req(1'b1, 1'b0, LW, 32'h00000010, 32'h0);
        run_req(1'b1, 1'b0, LW, 32'h00000002, 32'h0);
        run_req(1'b0, 1'b1, SH, 32'h00000001, 32'h0000BEEF);
        run_req(1'b0, 1'b1, ADD, 32'h00000020, 32'h11111111);
        run_req(1'b1, 1'b1, LW, 32'h00000020, 32'h0);
        run_req(1'b0, 1'b1, SH, 32'hFFFF0036, 32'h0000A55A);
        run_req(1'b1, 1'b0, LW, 32'hABCD0034, 32'h0);

        // Held req_valid across three loads: one accept every four cycles.
        eld = ref_word(16'h40 >> 2);
        @(negedge clk);
        req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; alucode = LW; addr = 32'h40;
        exp_daddr = 14'h10;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("held_ready", req_ready, (i % 4) == 0);
            check("held_resp", resp_valid, (i % 4) == 3);
            check("held_stall", stall, (i % 4) != 3);
            if (i % 4 == 3) check("held_data", load_data, eld);
        end
        req_valid = 1'b0;

        // Reset during the WRITE cycle suppresses the write and the response.
        @(negedge clk);
        req_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; alucode = SW;
        addr = 32'h00000080; store_data = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_we", dmem_we, 4'hF);
        rst = 1'b1;
        #1;
        check("midrst_we", dmem_we, 0);
        check("midrst_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_daddr = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_noresp", resp_valid, 0);
        end
        check("midrst_mem", mem[32], ref_word(32));
        run_req(1'b0, 1'b1, SW, 32'h00000080, 32'h0BADC0DE);
        run_req(1'b1, 1'b0, LW, 32'h00000080, 32'h0);

        // Randomized requests over a small window, sometimes with high address bits set.
        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, 8)];
            st = (op == SB || op == SH || op == SW) || (op == ADD && $urandom_range(0, 1) == 1);
            ld = !st;
            kind = $urandom_range(0, 9);
            if (kind == 8) begin ld = 1'b1; st = 1'b1; end
            if (kind == 9) begin ld = !ld; st = !st; end
            a = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF0000);
            run_req(ld, st, op, a, $urandom);
        end

        @(negedge clk);
        for (int i = 0; i < 128; i++) check("mem_final", mem[i], ref_word(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
